// File: rtl/dsp19x2_fir_sequencer.sv
// dsp19x2_fir_sequencer: feeds delayed samples and coefficient indices to a DSP19X2 MAC
// and captures the accumulated result into a one-entry valid/ready buffer.
module dsp19x2_fir_sequencer #(
    parameter int NUM_TAPS    = 4,
    parameter int DSP_LATENCY = 2
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        CLEAR,
    input  logic        S_VALID,
    output logic        S_READY,
    input  logic [8:0]  S_B1,
    input  logic [8:0]  S_B2,
    output logic [8:0]  DSP_B1,
    output logic [8:0]  DSP_B2,
    output logic [2:0]  DSP_FEEDBACK,
    output logic        DSP_LOAD_ACC,
    input  logic [18:0] DSP_Z1,
    input  logic [18:0] DSP_Z2,
    output logic        M_VALID,
    input  logic        M_READY,
    output logic [18:0] M_Z1,
    output logic [18:0] M_Z2,
    output logic        BUSY
);
    if (NUM_TAPS < 1 || NUM_TAPS > 4 || DSP_LATENCY < 1 || DSP_LATENCY > 3) begin : g_param_check
        $error("dsp19x2_fir_sequencer: NUM_TAPS must be 1..4 and DSP_LATENCY 1..3");
    end
    typedef enum logic [1:0] {IDLE, TAP, DRAIN} state_t;
    localparam logic [1:0] LAST_TAP   = 2'(NUM_TAPS - 1);
    localparam logic [1:0] LAST_DRAIN = 2'(DSP_LATENCY - 1);
    state_t     state;
    logic [8:0] x1 [4];
    logic [8:0] x2 [4];
    logic [1:0] tap, drain, tap_nx;
    assign tap_nx  = tap + 2'd1;
    // CLEAR wins over a simultaneous accept, so it gates readiness directly
    assign S_READY = state == IDLE && !M_VALID && !CLEAR;
    assign BUSY    = state != IDLE;
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state        <= IDLE;
            tap          <= '0;
            drain        <= '0;
            for (int i = 0; i < 4; i++) begin
                x1[i] <= '0;
                x2[i] <= '0;
            end
            DSP_B1       <= '0;
            DSP_B2       <= '0;
            DSP_FEEDBACK <= '0;
            DSP_LOAD_ACC <= 1'b0;
            M_VALID      <= 1'b0;
            M_Z1         <= '0;
            M_Z2         <= '0;
        end else begin
            if (M_VALID && M_READY) M_VALID <= 1'b0;
            case (state)
                IDLE: begin
                    if (CLEAR) begin
                        for (int i = 0; i < 4; i++) begin
                            x1[i] <= '0;
                            x2[i] <= '0;
                        end
                    end else if (S_VALID && S_READY) begin
                        for (int i = 3; i > 0; i--) begin
                            x1[i] <= x1[i-1];
                            x2[i] <= x2[i-1];
                        end
                        x1[0]        <= S_B1;
                        x2[0]        <= S_B2;
                        state        <= TAP;
                        tap          <= '0;
                        DSP_B1       <= S_B1;
                        DSP_B2       <= S_B2;
                        DSP_FEEDBACK <= '0;
                        DSP_LOAD_ACC <= 1'b1;
                    end
                end
                TAP: begin
                    DSP_LOAD_ACC <= 1'b0;
                    if (tap == LAST_TAP) begin
                        state        <= DRAIN;
                        drain        <= '0;
                        DSP_B1       <= '0;
                        DSP_B2       <= '0;
                        DSP_FEEDBACK <= '0;
                    end else begin
                        tap          <= tap_nx;
                        DSP_B1       <= x1[tap_nx];
                        DSP_B2       <= x2[tap_nx];
                        DSP_FEEDBACK <= {1'b0, tap_nx};
                    end
                end
                DRAIN: begin
                    if (drain == LAST_DRAIN) begin
                        state   <= IDLE;
                        M_Z1    <= DSP_Z1;
                        M_Z2    <= DSP_Z2;
                        M_VALID <= 1'b1;
                    end else begin
                        drain <= drain + 2'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
